// File: rtl/ip_forward.sv
// Pipelined single-precision dot-product engine: WIDTH parallel multipliers
// feeding a fixed-order binary adder tree. One result per cycle, no stall.
// The tag travels in a shift register of the same depth as the data.
module ip_forward #(
  parameter int WIDTH    = 8,
  parameter int MULT_LAT = 5,
  parameter int ADD_LAT  = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data [WIDTH-1:0],
  input  logic [31:0] weights [WIDTH-1:0],
  input  logic [7:0]  in_id,
  output logic [31:0] out_data,
  output logic [7:0]  out_id
);

  localparam int LVLS  = $clog2(WIDTH);
  localparam int TOTAL = MULT_LAT + ADD_LAT * LVLS + 1;
  localparam int NODES = 2 * WIDTH - 1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // binary32 multiply, RNE, subnormals in and out flushed to signed zero
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s, g, st;
    logic        an, bn, ai, bi, az, bz;
    logic [47:0] pr;
    logic [24:0] mr;
    int          e;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    az = (a[30:23] == 8'h00);
    bz = (b[30:23] == 8'h00);
    s  = a[31] ^ b[31];
    if (an || bn) return QNAN;
    if ((ai && bz) || (bi && az)) return QNAN;
    if (ai || bi) return {s, 8'hFF, 23'd0};
    if (az || bz) return {s, 31'd0};
    pr = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (pr[47]) begin
      mr = {1'b0, pr[47:24]}; g = pr[23]; st = |pr[22:0]; e = e + 1;
    end else begin
      mr = {1'b0, pr[46:23]}; g = pr[22]; st = |pr[21:0];
    end
    if (g && (st || mr[0])) mr = mr + 25'd1;
    if (mr[24]) begin mr = mr >> 1; e = e + 1; end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], mr[22:0]};
  endfunction

  // binary32 add, RNE, FTZ; exact cancellation yields +0
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [49:0] mx, my, sm;
    logic [24:0] mr;
    logic        g, st;
    logic        an, bn, ai, bi, az, bz;
    int          d, p, e;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    az = (a[30:23] == 8'h00);
    bz = (b[30:23] == 8'h00);
    if (an || bn) return QNAN;
    if (ai && bi) return (a[31] != b[31]) ? QNAN : a;
    if (ai) return a;
    if (bi) return b;
    if (az && bz) return {a[31] & b[31], 31'd0};
    if (az) return b;
    if (bz) return a;
    // x carries the larger magnitude and so the result sign
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    d  = int'(x[30:23]) - int'(y[30:23]);
    mx = {2'b01, x[22:0], 25'd0};
    my = {2'b01, y[22:0], 25'd0};
    // 25 guard bits below the lsb; shifted-out bits collapse into bit 0
    if (d > 49) my = 50'd1;
    else if (d > 0) begin
      st = |(my & ((50'd1 << d) - 50'd1));
      my = my >> d;
      my[0] = my[0] | st;
    end
    sm = (x[31] ^ y[31]) ? (mx - my) : (mx + my);
    if (sm == 50'd0) return 32'd0;
    p = 0;
    for (int i = 0; i < 50; i++) if (sm[i]) p = i;
    e  = int'(x[30:23]) + p - 48;
    sm = sm << (49 - p);
    mr = {1'b0, sm[49:26]}; g = sm[25]; st = |sm[24:0];
    if (g && (st || mr[0])) mr = mr + 25'd1;
    if (mr[24]) begin mr = mr >> 1; e = e + 1; end
    if (e >= 255) return {x[31], 8'hFF, 23'd0};
    if (e <= 0) return {x[31], 31'd0};
    return {x[31], e[7:0], mr[22:0]};
  endfunction

  // Tree nodes: [0..WIDTH-1] products, then each level's sums packed after
  // the previous level, root at NODES-1.
  logic [31:0] node [NODES];

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic [31:0] mul_q [MULT_LAT];
    // multiply in the first stage; the remaining stages give retiming room
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k < MULT_LAT; k++) mul_q[k] <= '0;
      end else begin
        mul_q[0] <= fmul(in_data[i], weights[i]);
        for (int k = 1; k < MULT_LAT; k++) mul_q[k] <= mul_q[k-1];
      end
    end
    assign node[i] = mul_q[MULT_LAT-1];
  end

  for (genvar l = 1; l <= LVLS; l++) begin : g_lvl
    localparam int NIN = WIDTH >> (l - 1);
    localparam int BI  = 2 * WIDTH - 2 * NIN;
    localparam int BO  = 2 * WIDTH - NIN;
    for (genvar j = 0; j < NIN / 2; j++) begin : g_add
      logic [31:0] add_q [ADD_LAT];
      // adjacent-pair sum, fixed association order for bit-exact results
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < ADD_LAT; k++) add_q[k] <= '0;
        end else begin
          add_q[0] <= fadd(node[BI+2*j], node[BI+2*j+1]);
          for (int k = 1; k < ADD_LAT; k++) add_q[k] <= add_q[k-1];
        end
      end
      assign node[BO+j] = add_q[ADD_LAT-1];
    end
  end

  logic [31:0] out_q;
  logic [7:0]  id_q [TOTAL];

  // final output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_q <= '0;
    else        out_q <= node[NODES-1];
  end

  // tag delay line matched to the full data latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TOTAL; k++) id_q[k] <= '0;
    end else begin
      id_q[0] <= in_id;
      for (int k = 1; k < TOTAL; k++) id_q[k] <= id_q[k-1];
    end
  end

  assign out_data = out_q;
  assign out_id   = id_q[TOTAL-1];

endmodule

// File: tb/tb_ip_forward.sv
// Directed and randomized checks for ip_forward with default parameters.
module tb_ip_forward;
  localparam int W   = 8;
  localparam int LAT = 27;

  logic        clk, reset;
  logic [31:0] in_data [7:0];
  logic [31:0] weights [7:0];
  logic [7:0]  in_id;
  logic [31:0] out_data;
  logic [7:0]  out_id;

  int n_vec = 0;
  int n_err = 0;

  ip_forward dut (
    .clk(clk), .reset(reset), .in_data(in_data), .weights(weights),
    .in_id(in_id), .out_data(out_data), .out_id(out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_all(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < W; i++) begin in_data[i] = a; weights[i] = w; end
  endtask

  // present current operands, wait the pipeline depth, compare
  task automatic run(input string tag, input logic [31:0] exp, input logic [7:0] id);
    in_id = id;
    repeat (LAT) tick();
    chk(tag, out_data, exp);
    chk({tag, "_id"}, {24'd0, out_id}, {24'd0, id});
  endtask

  // reference: exact double arithmetic rounded to binary32 after every op
  function automatic real s2r(input logic [31:0] f);
    logic [10:0] ex;
    if (f[30:23] == 8'd0) return $bitstoreal({f[31], 63'd0});
    ex = 11'(int'(f[30:23]) - 127 + 1023);
    return $bitstoreal({f[31], ex, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [24:0] m;
    logic        g, st;
    int          e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e  = int'(d[62:52]) - 1023 + 127;
    m  = {2'b01, d[51:29]};
    g  = d[28];
    st = |d[27:0];
    if (g && (st || m[0])) m = m + 25'd1;
    if (m[24]) begin m = m >> 1; e = e + 1; end
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0) return {d[63], 31'd0};
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] ref_dot();
    logic [31:0] v [8];
    for (int i = 0; i < W; i++) v[i] = r2s(s2r(in_data[i]) * s2r(weights[i]));
    for (int n = W / 2; n >= 1; n = n / 2)
      for (int j = 0; j < n; j++) v[j] = r2s(s2r(v[2*j]) + s2r(v[2*j+1]));
    return v[0];
  endfunction

  logic [31:0] exq [30];
  logic [31:0] seq [8];
  int stale;

  initial begin
    seq[0] = 32'h3F800000; seq[1] = 32'h40000000; seq[2] = 32'h40400000; seq[3] = 32'h40800000;
    seq[4] = 32'h40A00000; seq[5] = 32'h40C00000; seq[6] = 32'h40E00000; seq[7] = 32'h41000000;
    reset = 1'b0;
    set_all(32'h3F800000, 32'h3F800000);
    in_id = 8'h05;
    repeat (3) tick();
    chk("rst_data", out_data, 32'h0);
    chk("rst_id", {24'd0, out_id}, 32'h0);
    reset = 1'b1;

    run("ones", 32'h41000000, 8'h05);
    repeat (5) tick();
    chk("hold", out_data, 32'h41000000);

    for (int i = 0; i < W; i++) begin in_data[i] = seq[i]; weights[i] = 32'h3F800000; end
    run("seq36", 32'h42100000, 8'h11);
    for (int i = 0; i < W; i++) weights[i] = 32'h40000000;
    run("seq72", 32'h42900000, 8'h12);

    for (int i = 0; i < W; i++) begin
      in_data[i] = 32'h3F800000;
      weights[i] = i[0] ? 32'hBF800000 : 32'h3F800000;
    end
    run("cancel", 32'h00000000, 8'h13);
    in_data[0] = 32'h7FC00001;
    run("nan", 32'h7FC00000, 8'h14);

    set_all(32'h7F000000, 32'h7F000000);
    run("ovf", 32'h7F800000, 8'h15);
    set_all(32'h3F800000, 32'h3F800000);
    in_data[3] = 32'h7F800000; weights[3] = 32'h00000000;
    run("inf_x0", 32'h7FC00000, 8'h16);
    set_all(32'h3F800000, 32'h3F800000);
    in_data[0] = 32'h7F800000; in_data[1] = 32'hFF800000;
    run("inf_minf", 32'h7FC00000, 8'h17);
    set_all(32'h40000000, 32'h3F800000);
    run("two16", 32'h41800000, 8'h18);
    set_all(32'h00400000, 32'h3F800000);
    run("sub_in", 32'h00000000, 8'h19);
    set_all(32'h80000000, 32'h3F800000);
    run("negzero", 32'h80000000, 8'h1A);
    set_all(32'h1F800000, 32'h1F800000);
    run("sub_out", 32'h00000000, 8'h1B);

    // reset with a result in flight; stale data must never come out
    for (int i = 0; i < W; i++) begin in_data[i] = seq[i]; weights[i] = 32'h40000000; end
    in_id = 8'h21;
    repeat (10) tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_data", out_data, 32'h0);
    chk("arst_id", {24'd0, out_id}, 32'h0);
    set_all(32'h3F800000, 32'h3F800000);
    in_id = 8'h33;
    repeat (3) tick();
    chk("rst_hold", {out_id, out_data[23:0]} | {24'd0, out_data[31:24]}, 32'h0);
    reset = 1'b1;
    stale = 0;
    for (int k = 1; k < LAT; k++) begin
      tick();
      if (out_data != 32'h0 || out_id != 8'h0) stale++;
    end
    chk("no_stale", stale, 32'h0);
    tick();
    chk("post_rst", out_data, 32'h41000000);
    chk("post_rst_id", {24'd0, out_id}, 32'h33);

    // back-to-back random vectors: exact latency, ordering, tag alignment
    for (int t = 0; t < 30 + LAT; t++) begin
      if (t >= LAT) begin
        chk("rnd_data", out_data, exq[t-LAT]);
        chk("rnd_id", {24'd0, out_id}, 32'(8'h40 + 8'(t - LAT)));
      end
      if (t < 30) begin
        for (int i = 0; i < W; i++) begin
          in_data[i] = {1'($urandom), 8'($urandom_range(131, 124)), 23'($urandom)};
          weights[i] = {1'($urandom), 8'($urandom_range(131, 124)), 23'($urandom)};
        end
        in_id  = 8'h40 + 8'(t);
        exq[t] = ref_dot();
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
